map_ram_arbiter: RTL and testbench
==================================

// Module: map_ram_arbiter
// PURPOSE
// Shares the single-port 80x50 tile-map RAM between three requesters: the display read path
// (a pixel's matrix index, built from the pixel-to-tile mapping) and two game-logic ports.
// Converts (x,y) tile indices to a linear address, arbitrates per cycle and pipelines RAM
// accesses. Returns read data tagged to the originating port. Sits between the display
// front end / game FSMs and the map RAM.
// PARAMETERS
// MAP_W      80  tiles per row (x range 0..MAP_W-1)
// MAP_H      50  tile rows (y range 0..MAP_H-1)
// DATA_W     4   bits per tile entry
// RAM_LAT    1   RAM read latency in cycles (ram_en cycle -> ram_rdata valid), 1..3
// STARVE_MAX 15  cycles a game request may wait before it overrides the display port
// PORTS
// clk          in   1       system clock
// rst_n        in   1       synchronous reset, active-low
// disp_req     in   1       display read request
// disp_x       in   7       display tile index x
// disp_y       in   6       display tile index y
// disp_gnt     out  1       display request accepted this cycle (combinational)
// disp_rvalid  out  1       display read data valid
// disp_rdata   out  DATA_W  display read data
// disp_miss    out  1       pulse: display request denied by starvation override
// gN_req       in   1       game port N (N=0,1) request
// gN_we        in   1       1=write, 0=read
// gN_x / gN_y  in   7 / 6   tile index
// gN_wdata     in   DATA_W  write data
// gN_gnt       out  1       game port N accepted this cycle (combinational)
// gN_rvalid    out  1       game port N read data valid
// gN_rdata     out  DATA_W  game port N read data
// ram_en       out  1       RAM access strobe (registered)
// ram_we       out  1       RAM write enable (registered)
// ram_addr     out  12      linear address y*MAP_W+x (registered)
// ram_wdata    out  DATA_W  RAM write data (registered)
// ram_rdata    in   DATA_W  RAM read data, RAM_LAT cycles after ram_en
// oob_err      out  1       pulse: accepted request had x>=MAP_W or y>=MAP_H
// BEHAVIOUR
// - Handshake: request accepted on a rising edge where req&gnt=1. Requester holds req and
//   payload stable until accepted. At most one gnt high per cycle.
// - Priority: display > game; game ports round-robin (pointer starts at g0, moves to the
//   other port after each game grant). A lone requester is granted every cycle.
// - Starvation: per-port wait counter increments each cycle gN_req=1 and not granted, clears
//   on grant. When counter==STARVE_MAX, that port beats display; if display also requests,
//   disp_miss=1 that cycle. If both counters saturate, the round-robin pointer decides.
// - Address: ram_addr = (y<<6)+(y<<4)+x (no multiplier), 12-bit result, max 3999.
// - Timing: accept at edge N -> ram_en/ram_we/ram_addr/ram_wdata valid cycle N+1 ->
//   rvalid with rdata in cycle N+1+RAM_LAT, single-cycle pulse. Writes produce no rvalid.
//   Throughput: one access per cycle, back-to-back accepts allowed.
// - Tag pipeline: RAM_LAT+1 deep shift register carrying {valid, owner[1:0], oob}.
// - Out-of-bounds: request still accepted; ram_en stays 0; oob_err pulses in cycle N+1;
//   if a read, rvalid still fires at N+1+RAM_LAT with rdata=0; write discarded.
// - rdata outputs hold their last value when rvalid=0.
// - Reset (rst_n=0 at edge): all outputs 0 (ram_addr=0, rdata=0), pointer=g0, wait
//   counters=0, tag pipeline cleared; in-flight reads dropped, no rvalid after reset.
//   gnt outputs forced 0 while rst_n=0.
// TESTING
// 1 disp_req, (x,y)=(5,2) -> disp_gnt same cycle; ram_addr=165 next cycle; disp_rvalid with
//   ram_rdata after RAM_LAT more cycles; g0/g1 rvalid stay 0.
// 2 g0,g1 both request reads, no display, 4 cycles -> grants g0,g1,g0,g1; rvalid order same.
// 3 g0 write (79,49,data=0xA) then read same tile -> ram_addr=3999 both; read returns 0xA.
// 4 disp_req held high 20 cycles, g1_req high -> g1 granted after exactly 15 wait cycles;
//   disp_miss=1 that cycle only; display granted again next cycle.
// 5 g0 read (80,0) -> gnt=1, ram_en=0, oob_err pulse at N+1, g0_rvalid with rdata=0 at N+2.
// 6 accept reads on 3 consecutive cycles, rst_n low at 2nd ram_en -> no rvalid afterwards;
//   all outputs 0; pointer=g0 after release.

Source files
------------

// File: rtl/map_ram_arbiter.sv
// rtl/map_ram_arbiter.sv - tile-map RAM arbiter: display port plus two round-robin game ports
// Display wins unless a game port has waited STARVE_MAX cycles; read data returns tagged to its owner.
module map_ram_arbiter #(
  parameter int MAP_W      = 80,
  parameter int MAP_H      = 50,
  parameter int DATA_W     = 4,
  parameter int RAM_LAT    = 1,
  parameter int STARVE_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [6:0]        disp_x,
  input  logic [5:0]        disp_y,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_miss,
  input  logic              g0_req,
  input  logic              g0_we,
  input  logic [6:0]        g0_x,
  input  logic [5:0]        g0_y,
  input  logic [DATA_W-1:0] g0_wdata,
  output logic              g0_gnt,
  output logic              g0_rvalid,
  output logic [DATA_W-1:0] g0_rdata,
  input  logic              g1_req,
  input  logic              g1_we,
  input  logic [6:0]        g1_x,
  input  logic [5:0]        g1_y,
  input  logic [DATA_W-1:0] g1_wdata,
  output logic              g1_gnt,
  output logic              g1_rvalid,
  output logic [DATA_W-1:0] g1_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [11:0]       ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              oob_err
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [1:0] OWN_DISP = 2'd0;
  localparam logic [1:0] OWN_G0   = 2'd1;
  localparam logic [1:0] OWN_G1   = 2'd2;

  typedef struct packed {
    logic       valid;
    logic [1:0] owner;
    logic       oob;
  } tag_t;

  logic [CNT_W-1:0]  wait0_q, wait0_d, wait1_q, wait1_d;
  logic              ptr_q, ptr_d;
  logic              starve0, starve1;
  logic              gnt_disp, gnt_g0, gnt_g1, miss;
  logic              accept, sel_we, sel_oob;
  logic [6:0]        sel_x;
  logic [5:0]        sel_y;
  logic [DATA_W-1:0] sel_wdata;
  logic [1:0]        sel_owner;
  logic [11:0]       sel_addr;
  logic              ram_en_q, ram_we_q, oob_err_q;
  logic [11:0]       ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  tag_t              tag_q [RAM_LAT+1];
  logic              rvalid_any;
  logic [DATA_W-1:0] ret_data;
  logic [DATA_W-1:0] disp_rdata_q, g0_rdata_q, g1_rdata_q;

  assign starve0 = g0_req && (wait0_q == CNT_W'(STARVE_MAX));
  assign starve1 = g1_req && (wait1_q == CNT_W'(STARVE_MAX));

  // Starved game ports preempt display; ties between game ports go to the pointer.
  always_comb begin
    gnt_disp = 1'b0;
    gnt_g0   = 1'b0;
    gnt_g1   = 1'b0;
    miss     = 1'b0;
    if (rst_n) begin
      if (starve0 || starve1) begin
        miss = disp_req;
        if (starve0 && starve1) begin
          gnt_g0 = !ptr_q;
          gnt_g1 = ptr_q;
        end else begin
          gnt_g0 = starve0;
          gnt_g1 = starve1;
        end
      end else if (disp_req) begin
        gnt_disp = 1'b1;
      end else if (g0_req && g1_req) begin
        gnt_g0 = !ptr_q;
        gnt_g1 = ptr_q;
      end else begin
        gnt_g0 = g0_req;
        gnt_g1 = g1_req;
      end
    end
  end

  always_comb begin
    sel_x     = disp_x;
    sel_y     = disp_y;
    sel_we    = 1'b0;
    sel_wdata = '0;
    sel_owner = OWN_DISP;
    if (gnt_g0) begin
      sel_x     = g0_x;
      sel_y     = g0_y;
      sel_we    = g0_we;
      sel_wdata = g0_wdata;
      sel_owner = OWN_G0;
    end else if (gnt_g1) begin
      sel_x     = g1_x;
      sel_y     = g1_y;
      sel_we    = g1_we;
      sel_wdata = g1_wdata;
      sel_owner = OWN_G1;
    end
  end

  assign accept   = gnt_disp || gnt_g0 || gnt_g1;
  assign sel_oob  = (sel_x >= 7'(MAP_W)) || (sel_y >= 6'(MAP_H));
  assign sel_addr = {sel_y, 6'b0} + {2'b0, sel_y, 4'b0} + {5'b0, sel_x};

  always_comb begin
    wait0_d = wait0_q;
    wait1_d = wait1_q;
    ptr_d   = ptr_q;
    if (gnt_g0) wait0_d = '0;
    else if (g0_req && wait0_q != CNT_W'(STARVE_MAX)) wait0_d = wait0_q + CNT_W'(1);
    if (gnt_g1) wait1_d = '0;
    else if (g1_req && wait1_q != CNT_W'(STARVE_MAX)) wait1_d = wait1_q + CNT_W'(1);
    if (gnt_g0) ptr_d = 1'b1;
    else if (gnt_g1) ptr_d = 1'b0;
  end

  assign rvalid_any = rst_n && tag_q[RAM_LAT].valid;
  assign ret_data   = tag_q[RAM_LAT].oob ? '0 : ram_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait0_q      <= '0;
      wait1_q      <= '0;
      ptr_q        <= 1'b0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      oob_err_q    <= 1'b0;
      disp_rdata_q <= '0;
      g0_rdata_q   <= '0;
      g1_rdata_q   <= '0;
      for (int k = 0; k <= RAM_LAT; k++) tag_q[k] <= '0;
    end else begin
      wait0_q   <= wait0_d;
      wait1_q   <= wait1_d;
      ptr_q     <= ptr_d;
      ram_en_q  <= accept && !sel_oob;
      ram_we_q  <= accept && sel_we && !sel_oob;
      oob_err_q <= accept && sel_oob;
      if (accept) ram_addr_q <= sel_addr;
      if (accept && sel_we && !sel_oob) ram_wdata_q <= sel_wdata;
      tag_q[0] <= '{valid: accept && !sel_we, owner: sel_owner, oob: sel_oob};
      for (int k = 1; k <= RAM_LAT; k++) tag_q[k] <= tag_q[k-1];
      if (disp_rvalid) disp_rdata_q <= ret_data;
      if (g0_rvalid) g0_rdata_q <= ret_data;
      if (g1_rvalid) g1_rdata_q <= ret_data;
    end
  end

  assign disp_gnt    = gnt_disp;
  assign g0_gnt      = gnt_g0;
  assign g1_gnt      = gnt_g1;
  assign disp_miss   = miss;
  assign disp_rvalid = rvalid_any && (tag_q[RAM_LAT].owner == OWN_DISP);
  assign g0_rvalid   = rvalid_any && (tag_q[RAM_LAT].owner == OWN_G0);
  assign g1_rvalid   = rvalid_any && (tag_q[RAM_LAT].owner == OWN_G1);
  // rdata follows the RAM on the valid cycle and otherwise holds the last returned value.
  assign disp_rdata  = disp_rvalid ? ret_data : disp_rdata_q;
  assign g0_rdata    = g0_rvalid ? ret_data : g0_rdata_q;
  assign g1_rdata    = g1_rvalid ? ret_data : g1_rdata_q;
  assign ram_en      = ram_en_q;
  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign oob_err     = oob_err_q;

endmodule

// File: tb/tb_map_ram_arbiter.sv
// tb/tb_map_ram_arbiter.sv - self-checking bench for map_ram_arbiter
// Reference model predicts every output per cycle; directed tests add literal expectations.
module tb_map_ram_arbiter;
  localparam int DW  = 4;
  localparam int LAT = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          disp_req, disp_gnt, disp_rvalid, disp_miss;
  logic [6:0]    disp_x;
  logic [5:0]    disp_y;
  logic [DW-1:0] disp_rdata;
  logic          g0_req, g0_we, g0_gnt, g0_rvalid;
  logic [6:0]    g0_x;
  logic [5:0]    g0_y;
  logic [DW-1:0] g0_wdata, g0_rdata;
  logic          g1_req, g1_we, g1_gnt, g1_rvalid;
  logic [6:0]    g1_x;
  logic [5:0]    g1_y;
  logic [DW-1:0] g1_wdata, g1_rdata;
  logic          ram_en, ram_we, oob_err;
  logic [11:0]   ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  map_ram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .disp_req(disp_req), .disp_x(disp_x), .disp_y(disp_y), .disp_gnt(disp_gnt),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata), .disp_miss(disp_miss),
    .g0_req(g0_req), .g0_we(g0_we), .g0_x(g0_x), .g0_y(g0_y), .g0_wdata(g0_wdata),
    .g0_gnt(g0_gnt), .g0_rvalid(g0_rvalid), .g0_rdata(g0_rdata),
    .g1_req(g1_req), .g1_we(g1_we), .g1_x(g1_x), .g1_y(g1_y), .g1_wdata(g1_wdata),
    .g1_gnt(g1_gnt), .g1_rvalid(g1_rvalid), .g1_rdata(g1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .oob_err(oob_err)
  );

  function automatic logic [DW-1:0] init_val(int i);
    return 4'((i * 7 + 3) % 16);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Single-port RAM with one cycle of read latency; unwritten tiles read a fixed pattern.
  logic [DW-1:0] mem [int];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[int'(ram_addr)] = ram_wdata;
      else ram_rdata <= mem.exists(int'(ram_addr)) ? mem[int'(ram_addr)] : init_val(int'(ram_addr));
    end
  end

  // Reference model: win 0=none 1=disp 2=g0 3=g1
  logic [DW-1:0] ref_mem [int];
  int            w0 = 0, w1 = 0, ptr = 0, mcyc = 0;
  bit            started = 0, after_reset = 0;
  bit            e_en = 0, e_we = 0, e_oob = 0;
  int            e_addr = 0, e_wdata = 0;
  bit            ev_v [8];
  int            ev_own [8];
  int            ev_dat [8];
  int            held [3];

  always @(negedge clk) begin
    int win, mx, my, mwd, a, sl, own;
    bit miss, s0, s1, mwe, oob, rv;
    win = 0;
    miss = 0;
    s0 = g0_req && (w0 == 15);
    s1 = g1_req && (w1 == 15);
    if (rst_n) begin
      if (s0 || s1) begin
        miss = disp_req;
        win = (s0 && s1) ? (ptr ? 3 : 2) : (s0 ? 2 : 3);
      end else if (disp_req) win = 1;
      else if (g0_req && g1_req) win = ptr ? 3 : 2;
      else if (g0_req) win = 2;
      else if (g1_req) win = 3;
    end
    sl = mcyc % 8;
    rv = rst_n && ev_v[sl];
    own = ev_own[sl];
    if (started) begin
      chk("disp_gnt", disp_gnt, win == 1);
      chk("g0_gnt", g0_gnt, win == 2);
      chk("g1_gnt", g1_gnt, win == 3);
      chk("disp_miss", disp_miss, miss);
      chk("ram_en", ram_en, e_en);
      chk("ram_we", ram_we, e_we);
      chk("oob_err", oob_err, e_oob);
      if (e_en || after_reset) chk("ram_addr", ram_addr, e_addr);
      if ((e_en && e_we) || after_reset) chk("ram_wdata", ram_wdata, e_wdata);
      if (rv) held[own] = ev_dat[sl];
      chk("disp_rvalid", disp_rvalid, rv && own == 0);
      chk("g0_rvalid", g0_rvalid, rv && own == 1);
      chk("g1_rvalid", g1_rvalid, rv && own == 2);
      chk("disp_rdata", disp_rdata, held[0]);
      chk("g0_rdata", g0_rdata, held[1]);
      chk("g1_rdata", g1_rdata, held[2]);
    end
    ev_v[sl] = 0;
    if (!rst_n) begin
      started = 1;
      after_reset = 1;
      w0 = 0; w1 = 0; ptr = 0;
      e_en = 0; e_we = 0; e_oob = 0; e_addr = 0; e_wdata = 0;
      for (int i = 0; i < 8; i++) ev_v[i] = 0;
      for (int i = 0; i < 3; i++) held[i] = 0;
    end else begin
      after_reset = 0;
      e_en = 0; e_we = 0; e_oob = 0;
      if (win != 0) begin
        mx  = (win == 1) ? int'(disp_x) : (win == 2) ? int'(g0_x) : int'(g1_x);
        my  = (win == 1) ? int'(disp_y) : (win == 2) ? int'(g0_y) : int'(g1_y);
        mwe = (win == 2) ? g0_we : (win == 3) ? g1_we : 1'b0;
        mwd = (win == 2) ? int'(g0_wdata) : int'(g1_wdata);
        oob = (mx >= 80) || (my >= 50);
        a = my * 80 + mx;
        e_oob = oob;
        e_en = !oob;
        e_we = !oob && mwe;
        if (!oob) e_addr = a;
        e_wdata = mwd;
        if (mwe) begin
          if (!oob) ref_mem[a] = 4'(mwd);
        end else begin
          ev_v[(mcyc + 1 + LAT) % 8] = 1;
          ev_own[(mcyc + 1 + LAT) % 8] = win - 1;
          ev_dat[(mcyc + 1 + LAT) % 8] = oob ? 0 : (ref_mem.exists(a) ? int'(ref_mem[a]) : int'(init_val(a)));
        end
        if (win == 2) begin w0 = 0; ptr = 1; end
        if (win == 3) begin w1 = 0; ptr = 0; end
      end
      if (g0_req && win != 2) w0 = (w0 < 15) ? w0 + 1 : 15;
      if (g1_req && win != 3) w1 = (w1 < 15) ? w1 + 1 : 15;
    end
    mcyc++;
  end

  task automatic wait_gnt(input int port, input string name);
    bit got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = (port == 0) ? disp_gnt : (port == 1) ? g0_gnt : g1_gnt;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s: no grant within 40 cycles", name);
    end
  endtask

  initial begin
    int seq [4];
    bit dgnt [20];
    int g1_at, miss_at, miss_cnt, rv_cnt;
    disp_req = 0; disp_x = 0; disp_y = 0;
    g0_req = 0; g0_we = 0; g0_x = 0; g0_y = 0; g0_wdata = 0;
    g1_req = 0; g1_we = 0; g1_x = 0; g1_y = 0; g1_wdata = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // display read of (5,2)
    disp_req = 1; disp_x = 5; disp_y = 2;
    wait_gnt(0, "t1_gnt");
    @(posedge clk); #1 disp_req = 0;
    @(negedge clk);
    chk("t1_ram_addr", ram_addr, 165);
    chk("t1_ram_en", ram_en, 1);
    @(negedge clk);
    chk("t1_disp_rvalid", disp_rvalid, 1);
    chk("t1_disp_rdata", disp_rdata, 6);
    chk("t1_g0_rvalid", g0_rvalid, 0);

    // both game ports read: round-robin
    @(posedge clk); #1;
    g0_req = 1; g0_x = 1; g0_y = 1;
    g1_req = 1; g1_x = 2; g1_y = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seq[i] = g0_gnt ? 0 : (g1_gnt ? 1 : 9);
      @(posedge clk); #1;
    end
    g0_req = 0; g1_req = 0;
    for (int i = 0; i < 4; i++) chk("t2_rr_order", seq[i], i % 2);

    // write then read the last tile
    g0_req = 1; g0_we = 1; g0_x = 79; g0_y = 49; g0_wdata = 4'hA;
    wait_gnt(1, "t3_wr_gnt");
    @(posedge clk); #1 g0_we = 0;
    @(negedge clk);
    chk("t3_wr_addr", ram_addr, 3999);
    chk("t3_wr_we", ram_we, 1);
    chk("t3_wr_data", ram_wdata, 10);
    chk("t3_rd_gnt", g0_gnt, 1);
    @(posedge clk); #1 g0_req = 0;
    @(negedge clk);
    chk("t3_rd_addr", ram_addr, 3999);
    chk("t3_rd_we", ram_we, 0);
    @(negedge clk);
    chk("t3_rd_rvalid", g0_rvalid, 1);
    chk("t3_rd_data", g0_rdata, 10);

    // starvation override of a continuously requesting display
    @(posedge clk); #1;
    disp_req = 1; disp_x = 10; disp_y = 10;
    g1_req = 1; g1_we = 0; g1_x = 3; g1_y = 3;
    g1_at = -1; miss_at = -1; miss_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      dgnt[i] = disp_gnt;
      if (g1_gnt) g1_at = i;
      if (disp_miss) begin miss_cnt++; miss_at = i; end
      @(posedge clk); #1;
      if (g1_at == i) g1_req = 0;
    end
    disp_req = 0;
    chk("t4_g1_grant_cycle", g1_at, 15);
    chk("t4_miss_count", miss_cnt, 1);
    chk("t4_miss_cycle", miss_at, 15);
    chk("t4_disp_before", dgnt[14], 1);
    chk("t4_disp_after", dgnt[16], 1);

    // out-of-bounds read
    g0_req = 1; g0_we = 0; g0_x = 80; g0_y = 0;
    wait_gnt(1, "t5_gnt");
    @(posedge clk); #1 g0_req = 0;
    @(negedge clk);
    chk("t5_ram_en", ram_en, 0);
    chk("t5_oob_err", oob_err, 1);
    @(negedge clk);
    chk("t5_rvalid", g0_rvalid, 1);
    chk("t5_rdata", g0_rdata, 0);
    chk("t5_oob_clear", oob_err, 0);

    // reset with reads in flight
    @(posedge clk); #1;
    g0_req = 1; g0_x = 1; g0_y = 0;
    @(negedge clk); chk("t6_acc1", g0_gnt, 1);
    @(posedge clk); #1 g0_x = 2;
    @(negedge clk); chk("t6_acc2", g0_gnt, 1);
    @(posedge clk); #1 g0_x = 3; rst_n = 0;
    @(negedge clk);
    chk("t6_gnt_in_reset", g0_gnt, 0);
    chk("t6_ram_en_2nd", ram_en, 1);
    @(posedge clk); #1 rst_n = 1; g0_req = 0;
    @(negedge clk);
    chk("t6_ram_en", ram_en, 0);
    chk("t6_ram_addr", ram_addr, 0);
    chk("t6_g0_rdata", g0_rdata, 0);
    chk("t6_disp_rdata", disp_rdata, 0);
    rv_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (disp_rvalid || g0_rvalid || g1_rvalid) rv_cnt++;
      @(negedge clk);
    end
    chk("t6_no_rvalid", rv_cnt, 0);
    @(posedge clk); #1 g0_req = 1; g1_req = 1; g0_x = 4; g1_x = 5;
    @(negedge clk);
    chk("t6_ptr_g0", g0_gnt, 1);
    chk("t6_ptr_not_g1", g1_gnt, 0);
    @(posedge clk); #1 g0_req = 0; g1_req = 0;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
